router_modport: RTL and testbench



---
 rtl/router_modport.sv | 88 ++++++++
 tb/tb_router_modport.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_modport.sv
// router_modport: byte-serial packet router with parity/length check and a DEPTH-entry FIFO.
// Define ROUTER_SOFT_RESET_EN to flush the FIFO after TIMEOUT idle-read cycles.
module router_modport #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       error,
    input  logic       read_enb,
    output logic       vld_out,
    output logic [7:0] data_out
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
    state_t state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [5:0] len;
    logic [6:0] cnt;
    logic [7:0] par;
    logic empty, full, wr, rd, hdr, last, flush;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign busy    = (state == IDLE && !empty) || full || state == CHECK;
    assign vld_out = !empty;
    // not busy in IDLE already implies the FIFO is empty
    assign wr      = !busy && (state == LOAD || (state == IDLE && pkt_valid));
    assign rd      = read_enb && !empty;
    assign hdr     = wr && state == IDLE;
    assign last    = wr && state == LOAD && !pkt_valid;
    always_comb begin
        state_nxt = state;
        state_nxt = flush ? IDLE : hdr ? LOAD : last ? CHECK : state == CHECK ? IDLE : state;
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            len      <= '0;
            cnt      <= '0;
            par      <= '0;
            error    <= 1'b0;
            data_out <= 8'h00;
        end else begin
            state <= state_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr) wr_ptr <= wr_ptr + 1'b1;
                if (rd) rd_ptr <= rd_ptr + 1'b1;
            end
            if (rd) data_out <= mem[rd_ptr[AW-1:0]];
            if (hdr) begin
                len   <= data_in[7:2];
                cnt   <= '0;
                par   <= data_in;
                error <= 1'b0;
            end else if (wr && pkt_valid) begin
                cnt <= cnt + {6'd0, ~&cnt};
                par <= par ^ data_in;
            end else if (last) begin
                error <= (par != data_in) || (cnt != {1'b0, len});
            end
        end
    end
    always_ff @(posedge clock) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= data_in;
    end
`ifdef ROUTER_SOFT_RESET_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_cnt;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) idle_cnt <= '0;
        else idle_cnt <= (empty || read_enb || flush) ? '0 : idle_cnt + 1'b1;
    end
    assign flush = !empty && !read_enb && idle_cnt == TW'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign flush = 1'b0;
`endif
endmodule

// File: tb/tb_router_modport.sv
// tb_router_modport: randomized scoreboard bench for router_modport.
// Follows ROUTER_SOFT_RESET_EN when the bench is built with the same define.
module tb_router_modport;
    typedef logic [7:0] byte_q_t[$];
    logic clock = 1'b0, resetn = 1'b0, pkt_valid = 1'b0, read_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic busy, error, vld_out;
    logic [7:0] data_out;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic mon_pend = 1'b0;
    logic one_shot = 1'b0;
    int total = 0, bad = 0, rd_mode = 0;

    router_modport dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .busy(busy), .error(error), .read_enb(read_enb), .vld_out(vld_out), .data_out(data_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // sink: random reads, or one single pop on request
    initial forever begin
        @(negedge clock);
        if (one_shot) begin
            read_enb = 1'b1;
            one_shot = 1'b0;
        end else begin
            read_enb = rd_mode != 0 && $urandom_range(0, 1) == 1;
        end
    end

    // monitor: every pop is compared against the scoreboard head
    initial forever begin
        @(negedge clock);
        #1;
        if (mon_pend) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %h want no pop", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                check("data_out", data_out, mon_exp);
            end
        end
        mon_pend = resetn && read_enb && vld_out;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic pv, input logic [7:0] d);
        int n = 0;
        pkt_valid = pv;
        data_in = d;
        while (busy && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n == 300) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got busy for byte %h want accepted", d);
        end else begin
            exp_q.push_back(d);
        end
        @(negedge clock);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input byte_q_t pl, input logic [7:0] par);
        logic [7:0] x;
        x = hdr;
        send(1'b1, hdr);
        check("hdr_clears_error", 8'(error), 8'h00);
        foreach (pl[i]) begin
            send(1'b1, pl[i]);
            x ^= pl[i];
        end
        send(1'b0, par);
        check("error", 8'(error), 8'((x != par) || (pl.size() != int'(hdr[7:2]))));
        pkt_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        rd_mode = 1;
        while ((exp_q.size() != 0 || vld_out) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 8'(n >= 500), 8'h00);
        rd_mode = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic rand_pkt();
        byte_q_t pl;
        int len = $urandom_range(0, 20);
        int kind = $urandom_range(0, 2);
        int n = len;
        logic [7:0] hdr, x;
        hdr = {6'(len), 2'($urandom)};
        if (kind == 2) n = (len > 0 && $urandom_range(0, 1) == 1) ? len - 1 : len + 1;
        x = hdr;
        for (int i = 0; i < n; i++) begin
            pl.push_back(8'($urandom));
            x ^= pl[i];
        end
        if (kind == 1) x ^= 8'($urandom_range(1, 255));
        send_pkt(hdr, pl, x);
    endtask

    initial begin
        byte_q_t q;
        logic [7:0] x;
        repeat (3) @(negedge clock);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_error", 8'(error), 8'h00);
        check("rst_vld", 8'(vld_out), 8'h00);
        check("rst_data", data_out, 8'h00);
        resetn = 1'b1;
        @(negedge clock);

        q = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0C, q, 8'h0C);
        check("good_vld_up", 8'(vld_out), 8'h01);
        drain();
        check("good_vld_drop", 8'(vld_out), 8'h00);
        check("good_last", data_out, 8'h0C);

        rd_mode = 1;
        send_pkt(8'h0C, q, 8'hFF);
        check("bad_parity", 8'(error), 8'h01);
        q = '{8'h5A};
        send_pkt(8'h04, q, 8'h04 ^ 8'h5A);
        drain();

        // fill the FIFO with L=18 and no reads, then release one slot
        x = 8'h48;
        send(1'b1, 8'h48);
        for (int i = 0; i < 15; i++) begin
            send(1'b1, 8'(128 + i));
            x ^= 8'(128 + i);
            if (i == 13) check("busy_at_15", 8'(busy), 8'h00);
        end
        check("busy_full", 8'(busy), 8'h01);
        pkt_valid = 1'b1;
        data_in = 8'h90;
        one_shot = 1'b1;
        wait (!one_shot);
        @(negedge clock);
        check("busy_drop", 8'(busy), 8'h00);
        send(1'b1, 8'h90);
        rd_mode = 1;
        send(1'b1, 8'h91);
        send(1'b1, 8'h92);
        x ^= 8'h90 ^ 8'h91 ^ 8'h92;
        send(1'b0, x);
        pkt_valid = 1'b0;
        check("full_pkt_error", 8'(error), 8'h00);
        drain();

        q = '{8'hA1, 8'hB2, 8'hC3};
        rd_mode = 1;
        send_pkt(8'h08, q, 8'h08 ^ 8'hA1 ^ 8'hB2 ^ 8'hC3);
        check("len_mismatch", 8'(error), 8'h01);
        drain();

        // three bytes left unread: header at edge 0, then count edges
        q = '{8'h77};
        send_pkt(8'h04, q, 8'h00);
        repeat (27) @(negedge clock);
        check("soft_vld_29", 8'(vld_out), 8'h01);
        @(negedge clock);
`ifdef ROUTER_SOFT_RESET_EN
        check("soft_vld_30", 8'(vld_out), 8'h00);
        check("soft_error_kept", 8'(error), 8'h01);
        check("soft_busy", 8'(busy), 8'h00);
        exp_q.delete();
`else
        check("hold_vld_30", 8'(vld_out), 8'h01);
        repeat (10) @(negedge clock);
        check("hold_vld_40", 8'(vld_out), 8'h01);
        drain();
`endif

        // async reset in the middle of a payload with the FIFO full
        send(1'b1, 8'h50);
        for (int i = 0; i < 15; i++) send(1'b1, 8'($urandom));
        check("pre_rst_busy", 8'(busy), 8'h01);
        #2 resetn = 1'b0;
        pkt_valid = 1'b0;
        #1;
        check("async_busy", 8'(busy), 8'h00);
        check("async_error", 8'(error), 8'h00);
        check("async_vld", 8'(vld_out), 8'h00);
        check("async_data", data_out, 8'h00);
        exp_q.delete();
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        q = '{8'h01, 8'h02};
        rd_mode = 1;
        send_pkt(8'h0B, q, 8'h08);
        drain();

        rd_mode = 1;
        for (int p = 0; p < 12; p++) rand_pkt();
        drain();
        check("leftover", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
